// File: rtl/ad7606_par_reader.sv
`default_nettype none
// ============================================================================
// Module   : ad7606_par_reader
// Purpose  : Conversion scheduler and parallel-readout controller for the
//            AD7606. Starts a conversion every SAMPLE_DIV cycles, drives the
//            CONVST/RESET/CS/RD pins, follows BUSY through a two-flop
//            synchronizer and emits the eight 16-bit channel words of each
//            frame as a valid-only sample stream.
// Ports    : sys_clk, rst (async, active-high)
//            enable, os_cfg[2:0], range_cfg        - control / configuration
//            adc_reset, adc_convst_a/b, adc_cs_n,
//            adc_rd_n, adc_os[2:0], adc_range      - AD7606 pins
//            adc_busy, adc_data[15:0]              - AD7606 status / data bus
//            smp_valid, smp_ch[2:0], smp_data[15:0],
//            smp_last                              - sample stream
//            overrun (sticky), busy_timeout (pulse) - status
// Option   : define ADC_TEST_PATTERN_EN to replace the captured bus value by
//            {channel, frame_cnt[12:0]}; pin timing is identical.
// Timing parameters must fit in 16 bits.
// Revision : 1.0 - initial release
// ============================================================================
module ad7606_par_reader #(
    parameter int SAMPLE_DIV   = 1000,
    parameter int RESET_CYCLES = 10,
    parameter int CONVST_LOW   = 4,
    parameter int RD_LOW       = 3,
    parameter int RD_HIGH      = 2,
    parameter int BUSY_TO      = 255
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [2:0]  os_cfg,
    input  logic        range_cfg,
    output logic        adc_reset,
    output logic        adc_convst_a,
    output logic        adc_convst_b,
    output logic        adc_cs_n,
    output logic        adc_rd_n,
    output logic [2:0]  adc_os,
    output logic        adc_range,
    input  logic        adc_busy,
    input  logic [15:0] adc_data,
    output logic        smp_valid,
    output logic [2:0]  smp_ch,
    output logic [15:0] smp_data,
    output logic        smp_last,
    output logic        overrun,
    output logic        busy_timeout
);

    localparam logic [15:0] c_TMR_LAST  = 16'(SAMPLE_DIV - 1);
    localparam logic [15:0] c_RST_LAST  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] c_CONV_LAST = 16'(CONVST_LOW - 1);
    localparam logic [15:0] c_BTO_LAST  = 16'(BUSY_TO - 1);
    localparam logic [15:0] c_RDL_LAST  = 16'(RD_LOW - 1);
    localparam logic [15:0] c_RDH_LAST  = 16'(RD_HIGH - 1);

    typedef enum logic [2:0] {
        ST_ARST = 3'd0,
        ST_IDLE = 3'd1,
        ST_CONV = 3'd2,
        ST_WBH  = 3'd3,
        ST_WBL  = 3'd4,
        ST_READ = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_tmr;
    logic [15:0] r_cnt;        // per-state cycle counter
    logic [2:0]  r_ch;         // channel currently being read
    logic        r_rd_low;     // READ sub-phase: 1 = RD low, 0 = RD high gap
    logic        r_words_done; // all eight words read, waiting to release CS
    logic        r_busy_s1;
    logic        r_busy_s2;
    logic        r_adc_reset;
    logic        r_convst;
    logic        r_cs_n;
    logic        r_rd_n;
    logic [2:0]  r_os;
    logic        r_range;
    logic        r_smp_valid;
    logic [2:0]  r_smp_ch;
    logic [15:0] r_smp_data;
    logic        r_smp_last;
    logic        r_overrun;
    logic        r_busy_to;
`ifdef ADC_TEST_PATTERN_EN
    logic [12:0] r_frame_cnt;
    logic [12:0] w_frame_cnt_nxt;
`endif

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [15:0] w_tmr_nxt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  w_ch_nxt;
    logic        w_rd_low_nxt;
    logic        w_words_done_nxt;
    logic        w_adc_reset_nxt;
    logic        w_convst_nxt;
    logic        w_cs_n_nxt;
    logic        w_rd_n_nxt;
    logic [2:0]  w_os_nxt;
    logic        w_range_nxt;
    logic        w_smp_valid_nxt;
    logic [2:0]  w_smp_ch_nxt;
    logic [15:0] w_smp_data_nxt;
    logic        w_smp_last_nxt;
    logic        w_overrun_nxt;
    logic        w_busy_to_nxt;
    logic        w_tick;
    logic [15:0] w_word;

    // The timer is forced to 0 while disabled, so a tick can only occur
    // with enable high.
    assign w_tick = enable && (r_tmr == c_TMR_LAST);

`ifdef ADC_TEST_PATTERN_EN
    assign w_word = {r_ch, r_frame_cnt};
`else
    assign w_word = adc_data;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_tmr_nxt        = r_tmr;
        w_cnt_nxt        = r_cnt;
        w_ch_nxt         = r_ch;
        w_rd_low_nxt     = r_rd_low;
        w_words_done_nxt = r_words_done;
        w_adc_reset_nxt  = r_adc_reset;
        w_convst_nxt     = r_convst;
        w_cs_n_nxt       = r_cs_n;
        w_rd_n_nxt       = r_rd_n;
        w_os_nxt         = r_os;
        w_range_nxt      = r_range;
        w_smp_valid_nxt  = 1'b0;
        w_smp_ch_nxt     = r_smp_ch;
        w_smp_data_nxt   = r_smp_data;
        w_smp_last_nxt   = r_smp_last;
        w_overrun_nxt    = r_overrun;
        w_busy_to_nxt    = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
        w_frame_cnt_nxt  = r_frame_cnt;
`endif

        // Sample timer
        if (!enable || w_tick) begin
            w_tmr_nxt = 16'd0;
        end else begin
            w_tmr_nxt = r_tmr + 16'd1;
        end

        // A tick is only consumed in IDLE; anywhere else it is lost.
        if (w_tick && (r_state != ST_IDLE)) begin
            w_overrun_nxt = 1'b1;
        end

        case (r_state)
            ST_ARST: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt     = ST_IDLE;
                    w_adc_reset_nxt = 1'b0;
                    w_cnt_nxt       = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            ST_IDLE: begin
                w_os_nxt    = os_cfg;
                w_range_nxt = range_cfg;
                if (w_tick) begin
                    w_state_nxt  = ST_CONV;
                    w_convst_nxt = 1'b0;
                    w_cnt_nxt    = 16'd0;
                end
            end

            ST_CONV: begin
                if (r_cnt == c_CONV_LAST) begin
                    w_state_nxt  = ST_WBH;
                    w_convst_nxt = 1'b1;
                    w_cnt_nxt    = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            ST_WBH: begin
                if (r_busy_s2) begin
                    w_state_nxt = ST_WBL;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == c_BTO_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_busy_to_nxt = 1'b1;
                    w_cnt_nxt     = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            ST_WBL: begin
                if (!r_busy_s2) begin
                    // CS falls now; presetting the gap counter to its last
                    // value makes the CS-to-RD setup exactly one cycle.
                    w_state_nxt      = ST_READ;
                    w_cs_n_nxt       = 1'b0;
                    w_ch_nxt         = 3'd0;
                    w_rd_low_nxt     = 1'b0;
                    w_words_done_nxt = 1'b0;
                    w_cnt_nxt        = c_RDH_LAST;
                end
            end

            ST_READ: begin
                if (r_rd_low) begin
                    if (r_cnt == c_RDL_LAST) begin
                        // Last RD-low cycle: capture and release RD.
                        w_rd_n_nxt      = 1'b1;
                        w_rd_low_nxt    = 1'b0;
                        w_smp_valid_nxt = 1'b1;
                        w_smp_ch_nxt    = r_ch;
                        w_smp_data_nxt  = w_word;
                        w_smp_last_nxt  = (r_ch == 3'd7);
                        if (r_ch == 3'd7) begin
                            // One-cycle RD-high hold before CS rises.
                            w_words_done_nxt = 1'b1;
                            w_cnt_nxt        = c_RDH_LAST;
                        end else begin
                            w_ch_nxt  = r_ch + 3'd1;
                            w_cnt_nxt = 16'd0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end else begin
                    if (r_cnt == c_RDH_LAST) begin
                        if (r_words_done) begin
                            w_state_nxt = ST_IDLE;
                            w_cs_n_nxt  = 1'b1;
                            w_cnt_nxt   = 16'd0;
`ifdef ADC_TEST_PATTERN_EN
                            w_frame_cnt_nxt = r_frame_cnt + 13'd1;
`endif
                        end else begin
                            w_rd_n_nxt   = 1'b0;
                            w_rd_low_nxt = 1'b1;
                            w_cnt_nxt    = 16'd0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ARST;
            r_tmr        <= 16'd0;
            r_cnt        <= 16'd0;
            r_ch         <= 3'd0;
            r_rd_low     <= 1'b0;
            r_words_done <= 1'b0;
            r_busy_s1    <= 1'b0;
            r_busy_s2    <= 1'b0;
            r_adc_reset  <= 1'b1;
            r_convst     <= 1'b1;
            r_cs_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_os         <= 3'd0;
            r_range      <= 1'b0;
            r_smp_valid  <= 1'b0;
            r_smp_ch     <= 3'd0;
            r_smp_data   <= 16'd0;
            r_smp_last   <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy_to    <= 1'b0;
`ifdef ADC_TEST_PATTERN_EN
            r_frame_cnt  <= 13'd0;
`endif
        end else begin
            r_busy_s1    <= adc_busy;
            r_busy_s2    <= r_busy_s1;
            r_state      <= w_state_nxt;
            r_tmr        <= w_tmr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ch         <= w_ch_nxt;
            r_rd_low     <= w_rd_low_nxt;
            r_words_done <= w_words_done_nxt;
            r_adc_reset  <= w_adc_reset_nxt;
            r_convst     <= w_convst_nxt;
            r_cs_n       <= w_cs_n_nxt;
            r_rd_n       <= w_rd_n_nxt;
            r_os         <= w_os_nxt;
            r_range      <= w_range_nxt;
            r_smp_valid  <= w_smp_valid_nxt;
            r_smp_ch     <= w_smp_ch_nxt;
            r_smp_data   <= w_smp_data_nxt;
            r_smp_last   <= w_smp_last_nxt;
            r_overrun    <= w_overrun_nxt;
            r_busy_to    <= w_busy_to_nxt;
`ifdef ADC_TEST_PATTERN_EN
            r_frame_cnt  <= w_frame_cnt_nxt;
`endif
        end
    end

    assign adc_reset    = r_adc_reset;
    assign adc_convst_a = r_convst;
    assign adc_convst_b = r_convst;
    assign adc_cs_n     = r_cs_n;
    assign adc_rd_n     = r_rd_n;
    assign adc_os       = r_os;
    assign adc_range    = r_range;
    assign smp_valid    = r_smp_valid;
    assign smp_ch       = r_smp_ch;
    assign smp_data     = r_smp_data;
    assign smp_last     = r_smp_last;
    assign overrun      = r_overrun;
    assign busy_timeout = r_busy_to;

endmodule
`default_nettype wire

// File: tb/tb_ad7606_par_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad7606_par_reader
// Purpose  : Self-checking bench for ad7606_par_reader. Two instances: the
//            default parameter set and one with SAMPLE_DIV=64. A small
//            AD7606 model raises BUSY two cycles after CONVST rises and
//            serves per-channel words on the data bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad7606_par_reader;

    localparam int c_DIV = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, en64, range_cfg;
    logic [2:0] os_cfg;

    logic        adc_reset, convst_a, convst_b, cs_n, rd_n, adc_range;
    logic [2:0]  adc_os, smp_ch;
    logic [15:0] smp_data, data0, data1;
    logic        smp_valid, smp_last, overrun, busy_timeout;

    logic        adc_reset64, convst_a64, convst_b64, cs_n64, rd_n64, adc_range64;
    logic [2:0]  adc_os64, smp_ch64;
    logic [15:0] smp_data64;
    logic        smp_valid64, smp_last64, overrun64, busy_timeout64;

    // ADC model state, index 0 = default instance, 1 = SAMPLE_DIV=64 instance
    logic [1:0]  busy = 2'b00;
    int          busy_len [2] = '{0, 0};
    int          busy_dly [2] = '{0, 0};
    int          busy_rem [2] = '{0, 0};
    logic [2:0]  rd_idx   [2] = '{3'd0, 3'd0};
    logic        cv_prev  [2] = '{1'b1, 1'b1};
    logic        rd_prev  [2] = '{1'b1, 1'b1};
    logic [15:0] words    [2][8];
    logic [1:0]  m_cv, m_rd, m_cs;

    assign m_cv  = {convst_a64, convst_a};
    assign m_rd  = {rd_n64, rd_n};
    assign m_cs  = {cs_n64, cs_n};
    assign data0 = words[0][rd_idx[0]];
    assign data1 = words[1][rd_idx[1]];

    ad7606_par_reader dut (
        .sys_clk(clk), .rst(rst), .enable(enable), .os_cfg(os_cfg), .range_cfg(range_cfg),
        .adc_reset(adc_reset), .adc_convst_a(convst_a), .adc_convst_b(convst_b),
        .adc_cs_n(cs_n), .adc_rd_n(rd_n), .adc_os(adc_os), .adc_range(adc_range),
        .adc_busy(busy[0]), .adc_data(data0),
        .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data), .smp_last(smp_last),
        .overrun(overrun), .busy_timeout(busy_timeout)
    );

    ad7606_par_reader #(.SAMPLE_DIV(64)) dut64 (
        .sys_clk(clk), .rst(rst), .enable(en64), .os_cfg(os_cfg), .range_cfg(range_cfg),
        .adc_reset(adc_reset64), .adc_convst_a(convst_a64), .adc_convst_b(convst_b64),
        .adc_cs_n(cs_n64), .adc_rd_n(rd_n64), .adc_os(adc_os64), .adc_range(adc_range64),
        .adc_busy(busy[1]), .adc_data(data1),
        .smp_valid(smp_valid64), .smp_ch(smp_ch64), .smp_data(smp_data64), .smp_last(smp_last64),
        .overrun(overrun64), .busy_timeout(busy_timeout64)
    );

    // ADC behaviour, evaluated on the falling edge so it never races the DUT.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_cs[i]) rd_idx[i] = 3'd0;
            else if (!rd_prev[i] && m_rd[i]) rd_idx[i] = rd_idx[i] + 3'd1;
            rd_prev[i] = m_rd[i];
            if (busy_dly[i] > 0) begin
                busy_dly[i] = busy_dly[i] - 1;
                if (busy_dly[i] == 0) begin
                    busy[i]     = 1'b1;
                    busy_rem[i] = busy_len[i];
                end
            end else if (busy[i]) begin
                busy_rem[i] = busy_rem[i] - 1;
                if (busy_rem[i] == 0) busy[i] = 1'b0;
            end
            if (!cv_prev[i] && m_cv[i] && busy_len[i] > 0) busy_dly[i] = 2;
            cv_prev[i] = m_cv[i];
        end
    end

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int prev_fall = -1;
    int frames_done = 0;
    logic [2:0] exp_os = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_adc_reset"}, 32'(adc_reset), 1);
        chk({tag, "_convst"}, 32'({convst_a, convst_b}), 3);
        chk({tag, "_cs_rd"}, 32'({cs_n, rd_n}), 3);
        chk({tag, "_os_range"}, 32'({adc_os, adc_range}), 0);
        chk({tag, "_smp"}, 32'({smp_valid, smp_ch, smp_data, smp_last}), 0);
        chk({tag, "_flags"}, 32'({overrun, busy_timeout}), 0);
    endtask

    typedef struct {
        int       busy_len;
        bit       rnd;
        logic [2:0] os_mid;
        bit       drop_en;
        int       exp_n;
        bit       exp_to;
    } vec_t;

    vec_t vecs[9];

    task automatic run_frame(input vec_t v);
        int n, conv_w, n_to, t_fall, t_rise, t_to, t_csf, t_rd1, t_rdr, t_csr;
        logic got, done, cv_split, prev_rd, prev_cs;
        logic [2:0]  s_ch [16];
        logic [15:0] s_dat[16];
        logic        s_lst[16];
        int          s_t  [16];
        logic [15:0] expd;

        busy_len[0] = v.busy_len;
        for (int i = 0; i < 8; i++)
            words[0][i] = v.rnd ? 16'($urandom) : (16'h1000 + 16'(i));

        got = 1'b0;
        for (int k = 0; k < 2100; k++) begin
            step();
            if (!convst_a) begin got = 1'b1; break; end
        end
        chk("frame_start", 32'(got), 1);
        if (!got) return;

        t_fall = cyc;
        if (prev_fall >= 0) chk("tick_period", 32'(t_fall - prev_fall), c_DIV);
        prev_fall = v.drop_en ? -1 : t_fall;
        chk("os_at_start", 32'(adc_os), 32'(exp_os));
        if (v.drop_en) enable = 1'b0;

        n = 0; conv_w = 1; n_to = 0; t_rise = -1; t_to = -1;
        t_csf = -1; t_rd1 = -1; t_rdr = -1; t_csr = -1;
        done = 1'b0; cv_split = 1'b0; prev_rd = 1'b1; prev_cs = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            step();
            if (convst_a != convst_b) cv_split = 1'b1;
            if (!convst_a) conv_w++;
            else if (t_rise < 0) t_rise = cyc;
            if (busy_timeout) begin n_to++; if (t_to < 0) t_to = cyc; end
            if (prev_cs && !cs_n) t_csf = cyc;
            if (prev_rd && !rd_n && t_rd1 < 0) t_rd1 = cyc;
            if (!prev_rd && rd_n) t_rdr = cyc;
            if (!prev_cs && cs_n) begin t_csr = cyc; done = 1'b1; end
            if (smp_valid) begin
                if (n < 16) begin
                    s_ch[n] = smp_ch; s_dat[n] = smp_data; s_lst[n] = smp_last; s_t[n] = cyc;
                end
                n++;
                if (n == 1 && v.os_mid != 3'd0) begin
                    os_cfg = v.os_mid;
                    range_cfg = 1'b1;
                end
            end
            prev_rd = rd_n;
            prev_cs = cs_n;
            if (done) break;
            if (t_to >= 0 && cyc > t_to + 3) break;
        end

        chk("n_samples", 32'(n), 32'(v.exp_n));
        chk("timeout_pulses", 32'(n_to), 32'(v.exp_to));
        chk("convst_low_width", 32'(conv_w), 4);
        chk("convst_ab_together", 32'(cv_split), 0);
        if (v.exp_to) chk("timeout_latency", 32'(t_to - t_rise), 255);
        if (v.exp_n == 8 && n == 8) begin
            chk("cs_to_rd", 32'(t_rd1 - t_csf), 1);
            chk("rd_to_cs", 32'(t_csr - t_rdr), 1);
            for (int i = 0; i < 8; i++) begin
`ifdef ADC_TEST_PATTERN_EN
                expd = {3'(i), 13'(frames_done)};
`else
                expd = words[0][i];
`endif
                chk("smp_ch", 32'(s_ch[i]), 32'(i));
                chk("smp_data", 32'(s_dat[i]), 32'(expd));
                chk("smp_last", 32'(s_lst[i]), 32'(i == 7));
                if (i > 0) chk("word_spacing", 32'(s_t[i] - s_t[i-1]), 5);
            end
        end
        if (v.exp_n == 8) frames_done++;

        if (v.os_mid != 3'd0) begin
            chk("os_hold_to_end", 32'(adc_os), 32'(exp_os));
            step();
            step();
            chk("os_new", 32'(adc_os), 32'(v.os_mid));
            chk("range_new", 32'(adc_range), 1);
            exp_os = v.os_mid;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         frames, nf, bad, errs;
        logic       seen, dropped, prev_cs, got;
        logic [2:0] next_ch;

        rst = 1'b1; enable = 1'b0; en64 = 1'b0; os_cfg = 3'd0; range_cfg = 1'b0;
        for (int c = 0; c < 8; c++) begin
            words[0][c] = 16'h0;
            words[1][c] = 16'h4000 + 16'(c);
        end

        // Reset state and ARST length
        repeat (3) step();
        chk_reset_values("reset");
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("arst_len", 32'(adc_reset), 32'(k < 10));
        end
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if ({convst_a, convst_b, cs_n, rd_n} != 4'hF || smp_valid || overrun || busy_timeout) errs++;
        end
        chk("quiet_before_tick", 32'(errs), 0);

        // Table of frames: fixed corner cases followed by randomized frames
        vecs[0] = '{100, 1'b0, 3'd0, 1'b0, 8, 1'b0};
        vecs[1] = '{0,   1'b0, 3'd0, 1'b0, 0, 1'b1};
        vecs[2] = '{100, 1'b0, 3'd3, 1'b0, 8, 1'b0};
        for (int i = 3; i < 8; i++)
            vecs[i] = '{int'($urandom_range(150, 5)), 1'b1, 3'd0, 1'b0, 8, 1'b0};
        vecs[8] = '{60,  1'b1, 3'd0, 1'b1, 8, 1'b0};

        enable = 1'b1;
        for (int i = 0; i < 9; i++) run_frame(vecs[i]);
        chk("overrun_main_clear", 32'(overrun), 0);

        // SAMPLE_DIV=64 with a 200-cycle BUSY: overrun must set and stick
        busy_len[1] = 200;
        chk("ovr64_init", 32'(overrun64), 0);
        en64 = 1'b1;
        frames = 0; nf = 0; bad = 0; seen = 1'b0; dropped = 1'b0; prev_cs = 1'b1; next_ch = 3'd0;
        for (int k = 0; k < 1500; k++) begin
            step();
            if (smp_valid64) begin
                if (smp_ch64 != next_ch || smp_last64 != (next_ch == 3'd7)) bad++;
                next_ch = next_ch + 3'd1;
                nf++;
            end
            if (!prev_cs && cs_n64) begin
                chk("frame64_len", 32'(nf), 8);
                nf = 0;
                frames++;
            end
            if (overrun64) seen = 1'b1;
            else if (seen) dropped = 1'b1;
            prev_cs = cs_n64;
        end
        en64 = 1'b0;
        chk("frames64", 32'(frames >= 2), 1);
        chk("ovr64_set", 32'(seen), 1);
        chk("ovr64_sticky", 32'(dropped), 0);
        chk("ch64_order", 32'(bad), 0);

        // Reset asserted in the middle of READ
        busy_len[0] = 30;
        enable = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 2100; k++) begin
            step();
            if (!cs_n) begin got = 1'b1; break; end
        end
        chk("midframe_reach_read", 32'(got), 1);
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("midrst");
        chk("midrst_ovr64", 32'(overrun64), 0);
        step();
        step();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("arst_restart", 32'(adc_reset), 32'(k < 10));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
